mem_bus_ctrl: RTL and testbench
===============================

Name: mem_bus_ctrl

Overview:
- Memory-bus sequencer between the 8-state CPU controller and an external instruction/data memory with variable-latency req/ack handshake.
- Converts the controller's level strobes (rd, wr, sel, data_e) into single bus transactions, selects PC vs IR-operand address, and registers read data for IR/AC.
- Asserts stall so the controller's state register holds while a transaction is outstanding; stall is ORed into the controller's existing halt gating.

Parameters:
- AW, 5, address width (IR operand field / PC width)
- DW, 8, data width
- TIMEOUT, 15, max cycles mem_req may wait for mem_ack before bus error

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- sel  in  1  from controller: 1 = address from pc_addr, 0 = from ir_addr
- rd  in  1  from controller: read strobe (level, may span several cycles)
- wr  in  1  from controller: write strobe (level)
- data_e  in  1  from controller: enables ac_data onto write bus
- pc_addr  in  AW  program counter value
- ir_addr  in  AW  IR operand address field
- ac_data  in  DW  accumulator value for stores
- mem_addr  out  AW  memory address, registered
- mem_req  out  1  transaction request, held until ack
- mem_we  out  1  1 = write transaction
- mem_wdata  out  DW  write data, registered
- mem_rdata  in  DW  read data, valid with mem_ack
- mem_ack  in  1  one-cycle completion pulse
- data_out  out  DW  last read data, registered, held until next read completes
- data_valid  out  1  one-cycle pulse the cycle after read ack
- stall  out  1  controller must not advance
- bus_err  out  1  sticky error flag

Behaviour:
- Reset (rst=0, async): state IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, data_out=0, data_valid=0, bus_err=0, timeout counter=0; rd_q=wr_q=0. An in-flight transaction is abandoned: mem_req drops immediately.
- Edge detect: rd_q/wr_q register rd/wr each cycle. rd_start = rd & ~rd_q; wr_start = wr & ~wr_q. One transaction per strobe assertion regardless of strobe length.
- States: IDLE, RD_WAIT, WR_WAIT, ERR.
- IDLE: rd_start only -> latch mem_addr = sel ? pc_addr : ir_addr, mem_req=1, mem_we=0, go RD_WAIT. wr_start only -> latch address the same way, mem_wdata = data_e ? ac_data : 0, mem_req=1, mem_we=1, go WR_WAIT. rd_start & wr_start in the same cycle -> no transaction, bus_err=1, go ERR.
- RD_WAIT: mem_ack=1 -> data_out <= mem_rdata, data_valid=1 next cycle, mem_req=0, go IDLE. Else counter++; counter reaching TIMEOUT -> mem_req=0, bus_err=1, go ERR.
- WR_WAIT: same as RD_WAIT, except ack captures nothing and data_valid stays 0.
- ERR: terminal until reset; mem_req=0; further strobes ignored.
- Counter clears on every transaction start.
- Minimum latency: strobe edge at cycle 0, mem_req=1 at cycle 1, ack sampled at cycle 1, data_out/data_valid at cycle 2.
- stall (combinational) = rd_start | wr_start | (state in RD_WAIT, WR_WAIT, ERR). stall drops in the cycle data_valid rises.
- mem_ack in IDLE/ERR: ignored, no state change.
- Strobe edges arriving in RD_WAIT/WR_WAIT: ignored, since the controller is stalled and cannot produce them legally.
- mem_addr, mem_we and mem_wdata are stable for the entire mem_req high period.

Decomposition:
- Shared package cpu_pkg: AW/DW defaults, bus state encoding (IDLE=0, RD_WAIT=1, WR_WAIT=2, ERR=3), opcode constants already used by the controller.
- One natural sub-module: strobe_edge (registered rising-edge detector, reset-aware), instanced for rd and wr.

Test Plan:
- Read, fast ack: sel=1, pc_addr=5'h03, rd high 2 cycles, mem_ack on cycle 1 with rdata=8'hA5 -> mem_addr=03, single mem_req cycle, data_out=A5, data_valid pulse at cycle 2, stall high cycles 0–1 only.
- Write, 4-cycle ack: sel=0, ir_addr=5'h1F, data_e=1, ac_data=8'h3C, wr pulse -> mem_we=1, mem_addr=1F, mem_wdata=3C held 4 cycles, data_valid stays 0, data_out unchanged.
- Long strobe: rd high 6 cycles, ack at cycle 1 -> exactly one mem_req assertion; no second transaction.
- Timeout: rd pulse, never ack -> mem_req high TIMEOUT cycles then 0, bus_err=1, stall stays 1; later rd pulses produce no mem_req.
- Simultaneous rd and wr edge -> no mem_req, bus_err=1, state ERR.
- Reset mid-read: rst low during RD_WAIT -> mem_req=0 immediately (before next clk), all outputs at reset values; after release a new read completes normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-state CPU and its memory-bus sequencer.
//   - AW_DEF / DW_DEF : default address and data widths
//   - bus_state_e     : sequencer state encoding
//   - OP_*            : instruction opcodes decoded by the controller
package cpu_pkg;

  localparam int AW_DEF = 5;
  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {
    BUS_IDLE    = 2'd0,
    BUS_RD_WAIT = 2'd1,
    BUS_WR_WAIT = 2'd2,
    BUS_ERR     = 2'd3
  } bus_state_e;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

endpackage

// File: rtl/strobe_edge.sv
// Registered rising-edge detector for a level strobe.
//   clk    : clock, rising edge
//   rst    : asynchronous active-low reset
//   strobe : level input
//   rise   : high in the first cycle strobe is seen high
module strobe_edge (
  input  logic clk,
  input  logic rst,
  input  logic strobe,
  output logic rise
);

  logic strobe_q;

  // NOTE: flops are written with <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) strobe_q <= 1'b0;
    else      strobe_q <= strobe;
  end

  assign rise = strobe & ~strobe_q;

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory-bus sequencer between the CPU controller and a req/ack memory.
// Turns the controller's level strobes into single bus transactions, holds
// the controller with stall while a transaction is outstanding, and flags a
// sticky bus error on timeout or conflicting strobes.
//   clk, rst              : clock (rising edge), async active-low reset
//   sel, rd, wr, data_e   : controller strobes / address select / store enable
//   pc_addr, ir_addr      : candidate addresses
//   ac_data               : accumulator value for stores
//   mem_addr, mem_req, mem_we, mem_wdata : registered bus request
//   mem_rdata, mem_ack    : bus response
//   data_out, data_valid  : captured read data and its one-cycle pulse
//   stall, bus_err        : controller hold and sticky error
module mem_bus_ctrl
  import cpu_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sel,
  input  logic          rd,
  input  logic          wr,
  input  logic          data_e,
  input  logic [AW-1:0] pc_addr,
  input  logic [AW-1:0] ir_addr,
  input  logic [DW-1:0] ac_data,
  output logic [AW-1:0] mem_addr,
  output logic          mem_req,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic [DW-1:0] data_out,
  output logic          data_valid,
  output logic          stall,
  output logic          bus_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  bus_state_e    state, state_nxt;
  logic          rd_start, wr_start;
  logic [CW-1:0] cnt;
  logic          cnt_last;
  logic          launch_rd, launch_wr, ack_done, to_err;
  logic          in_wait;

  strobe_edge u_rd_edge (.clk(clk), .rst(rst), .strobe(rd), .rise(rd_start));
  strobe_edge u_wr_edge (.clk(clk), .rst(rst), .strobe(wr), .rise(wr_start));

  // Counter holds the number of ack-less wait cycles already spent; the
  // request is abandoned on the edge that would make it TIMEOUT.
  assign cnt_last = (cnt == CW'(TIMEOUT - 1));
  assign in_wait  = (state == BUS_RD_WAIT) || (state == BUS_WR_WAIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= BUS_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    state_nxt = state;
    launch_rd = 1'b0;
    launch_wr = 1'b0;
    ack_done  = 1'b0;
    to_err    = 1'b0;
    case (state)
      BUS_IDLE: begin
        if (rd_start && wr_start) begin
          to_err    = 1'b1;
          state_nxt = BUS_ERR;
        end else if (rd_start) begin
          launch_rd = 1'b1;
          state_nxt = BUS_RD_WAIT;
        end else if (wr_start) begin
          launch_wr = 1'b1;
          state_nxt = BUS_WR_WAIT;
        end
      end
      BUS_RD_WAIT, BUS_WR_WAIT: begin
        // Strobe edges here are ignored: the controller is stalled.
        if (mem_ack) begin
          ack_done  = 1'b1;
          state_nxt = BUS_IDLE;
        end else if (cnt_last) begin
          to_err    = 1'b1;
          state_nxt = BUS_ERR;
        end
      end
      default: state_nxt = BUS_ERR;  // BUS_ERR is terminal until reset
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr   <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      bus_err    <= 1'b0;
      cnt        <= '0;
    end else begin
      data_valid <= 1'b0;
      // Address/direction/data only change at launch, so they stay stable
      // for the whole time mem_req is high.
      if (launch_rd || launch_wr) begin
        mem_addr <= sel ? pc_addr : ir_addr;
        mem_req  <= 1'b1;
        mem_we   <= launch_wr;
        cnt      <= '0;
        if (launch_wr) mem_wdata <= data_e ? ac_data : '0;
      end
      if (ack_done) begin
        mem_req <= 1'b0;
        if (state == BUS_RD_WAIT) begin
          data_out   <= mem_rdata;
          data_valid <= 1'b1;
        end
      end else if (in_wait) begin
        cnt <= cnt + 1'b1;
      end
      if (to_err) begin
        mem_req <= 1'b0;
        bus_err <= 1'b1;
      end
    end
  end

  assign stall = rd_start | wr_start | (state != BUS_IDLE);

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed self-checking bench for mem_bus_ctrl.
module tb_mem_bus_ctrl;

  localparam int AW = 5;
  localparam int DW = 8;
  localparam int TO = 15;

  logic          clk, rst;
  logic          sel, rd, wr, data_e;
  logic [AW-1:0] pc_addr, ir_addr;
  logic [DW-1:0] ac_data;
  logic [AW-1:0] mem_addr;
  logic          mem_req, mem_we;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_ack;
  logic [DW-1:0] data_out;
  logic          data_valid, stall, bus_err;

  int n_checks = 0;
  int n_fail   = 0;
  int req_cycles;
  int dv_cycles;

  mem_bus_ctrl #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .sel(sel), .rd(rd), .wr(wr), .data_e(data_e),
    .pc_addr(pc_addr), .ir_addr(ir_addr), .ac_data(ac_data),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .data_out(data_out), .data_valid(data_valid), .stall(stall),
    .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // on the falling edge of the same cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; sel = 1'b0; rd = 1'b0; wr = 1'b0; data_e = 1'b0;
    pc_addr = '0; ir_addr = '0; ac_data = '0; mem_rdata = '0; mem_ack = 1'b0;

    // Reset values
    #2;
    check("rst_req",   mem_req,    0);
    check("rst_we",    mem_we,     0);
    check("rst_addr",  mem_addr,   0);
    check("rst_wdata", mem_wdata,  0);
    check("rst_dout",  data_out,   0);
    check("rst_dv",    data_valid, 0);
    check("rst_err",   bus_err,    0);
    check("rst_stall", stall,      0);
    @(posedge clk); #3; rst = 1'b1;
    step();

    // 1: read, fast ack
    rd = 1'b1; sel = 1'b1; pc_addr = 5'h03; ir_addr = 5'h0A;
    mid();
    check("rd1_c0_stall", stall,   1);
    check("rd1_c0_req",   mem_req, 0);
    step();
    mem_ack = 1'b1; mem_rdata = 8'hA5;
    mid();
    check("rd1_c1_req",   mem_req,  1);
    check("rd1_c1_addr",  mem_addr, 5'h03);
    check("rd1_c1_we",    mem_we,   0);
    check("rd1_c1_stall", stall,    1);
    check("rd1_c1_dv",    data_valid, 0);
    step();
    rd = 1'b0; mem_ack = 1'b0; mem_rdata = 8'h00;
    mid();
    check("rd1_c2_req",   mem_req,    0);
    check("rd1_c2_dout",  data_out,   8'hA5);
    check("rd1_c2_dv",    data_valid, 1);
    check("rd1_c2_stall", stall,      0);
    step();
    mid();
    check("rd1_c3_dv", data_valid, 0);
    step();

    // 2: write, ack in the 4th request cycle
    wr = 1'b1; sel = 1'b0; ir_addr = 5'h1F; data_e = 1'b1; ac_data = 8'h3C;
    mid();
    check("wr_c0_stall", stall, 1);
    step();
    wr = 1'b0; ac_data = 8'h55;  // must not reach the registered wdata
    for (int i = 1; i <= 4; i++) begin
      mem_ack = (i == 4);
      mid();
      check($sformatf("wr_c%0d_req", i),   mem_req,   1);
      check($sformatf("wr_c%0d_we", i),    mem_we,    1);
      check($sformatf("wr_c%0d_addr", i),  mem_addr,  5'h1F);
      check($sformatf("wr_c%0d_wdata", i), mem_wdata, 8'h3C);
      check($sformatf("wr_c%0d_dv", i),    data_valid, 0);
      check($sformatf("wr_c%0d_stall", i), stall,     1);
      step();
    end
    mem_ack = 1'b0;
    mid();
    check("wr_c5_req",   mem_req,    0);
    check("wr_c5_dv",    data_valid, 0);
    check("wr_c5_dout",  data_out,   8'hA5);
    check("wr_c5_stall", stall,      0);
    step();

    // 2b: write with data_e low drives zero data; address from pc
    wr = 1'b1; sel = 1'b1; pc_addr = 5'h07; data_e = 1'b0; ac_data = 8'hFF;
    step();
    wr = 1'b0; mem_ack = 1'b1;
    mid();
    check("wr0_addr",  mem_addr,  5'h07);
    check("wr0_wdata", mem_wdata, 8'h00);
    check("wr0_we",    mem_we,    1);
    step();
    mem_ack = 1'b0;
    mid();
    check("wr0_done_req", mem_req, 0);
    step();

    // 3: long read strobe yields exactly one transaction
    req_cycles = 0; dv_cycles = 0;
    sel = 1'b0; ir_addr = 5'h11;
    for (int i = 0; i < 8; i++) begin
      rd = (i < 6);
      mem_ack = (i == 1);
      mem_rdata = (i == 1) ? 8'h5A : 8'h00;
      mid();
      if (mem_req) req_cycles++;
      if (data_valid) dv_cycles++;
      step();
    end
    rd = 1'b0; mem_ack = 1'b0;
    check("long_req_cycles", req_cycles, 1);
    check("long_dv_pulses",  dv_cycles,  1);
    check("long_dout",       data_out,   8'h5A);
    check("long_addr",       mem_addr,   5'h11);

    // mem_ack in IDLE is ignored
    mem_ack = 1'b1; mem_rdata = 8'h77;
    mid();
    check("idle_ack_stall", stall, 0);
    step();
    mem_ack = 1'b0;
    mid();
    check("idle_ack_dv",   data_valid, 0);
    check("idle_ack_dout", data_out,   8'h5A);
    check("idle_ack_req",  mem_req,    0);
    step();

    // 6: asynchronous reset during RD_WAIT, then a normal read
    rd = 1'b1; sel = 1'b1; pc_addr = 5'h09;
    step();
    rd = 1'b0;
    mid();
    check("rstmid_req_before", mem_req, 1);
    #1 rst = 1'b0;
    #1;
    check("rstmid_req",   mem_req,    0);
    check("rstmid_addr",  mem_addr,   0);
    check("rstmid_dout",  data_out,   0);
    check("rstmid_err",   bus_err,    0);
    check("rstmid_stall", stall,      0);
    @(posedge clk); #3; rst = 1'b1;
    step();
    rd = 1'b1; pc_addr = 5'h0C;
    step();
    rd = 1'b0; mem_ack = 1'b1; mem_rdata = 8'hC3;
    mid();
    check("rstmid_rd_req",  mem_req,  1);
    check("rstmid_rd_addr", mem_addr, 5'h0C);
    step();
    mem_ack = 1'b0;
    mid();
    check("rstmid_rd_dout", data_out,   8'hC3);
    check("rstmid_rd_dv",   data_valid, 1);
    step();

    // 4: timeout, never acked
    rd = 1'b1; sel = 1'b1; pc_addr = 5'h02;
    step();
    rd = 1'b0; req_cycles = 0;
    for (int i = 1; i <= TO + 5; i++) begin
      mid();
      if (mem_req) req_cycles++;
      if (i == TO) begin
        check("to_last_req", mem_req, 1);
        check("to_last_err", bus_err, 0);
      end
      if (i == TO + 1) begin
        check("to_after_req",   mem_req, 0);
        check("to_after_err",   bus_err, 1);
        check("to_after_stall", stall,   1);
      end
      step();
    end
    check("to_req_cycles", req_cycles, TO);
    // strobes in ERR are ignored
    rd = 1'b1;
    step();
    rd = 1'b0;
    mid();
    check("err_rd_req",   mem_req, 0);
    check("err_rd_stall", stall,   1);
    check("err_sticky",   bus_err, 1);
    step();
    pulse_reset();
    step();

    // 5: simultaneous rd and wr edges
    check("sim_pre_err", bus_err, 0);
    rd = 1'b1; wr = 1'b1; sel = 1'b1; pc_addr = 5'h04;
    mid();
    check("sim_c0_stall", stall, 1);
    step();
    rd = 1'b0; wr = 1'b0;
    mid();
    check("sim_c1_req",   mem_req, 0);
    check("sim_c1_err",   bus_err, 1);
    check("sim_c1_stall", stall,   1);
    check("sim_c1_addr",  mem_addr, 0);
    step();
    mem_ack = 1'b1;
    mid();
    check("sim_ack_stall", stall, 1);
    step();
    mem_ack = 1'b0;
    mid();
    check("sim_ack_dv", data_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
